// File: rtl/design_sel_ctrl.sv
// Design-select controller for the 12-slot integration mux.
// Sequences every change as: old design reset -> quiesce -> all-off gap -> new select held in reset -> release.
module design_sel_ctrl #(
  parameter int NUM_DESIGNS     = 12,
  parameter int SEL_W           = 4,
  parameter int QUIESCE_CYCLES  = 16,
  parameter int RST_HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_id,
  output logic             req_ready,
  input  logic             kill,
  output logic [SEL_W-1:0] design_select,
  output logic             design_n_rst,
  output logic [SEL_W-1:0] active_id,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int MAX_CYC = (QUIESCE_CYCLES > RST_HOLD_CYCLES) ? QUIESCE_CYCLES : RST_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_GAP,
    S_HOLD,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [SEL_W-1:0] sel_d, active_d;
  logic             n_rst_d, ready_d, busy_d, done_d, err_d;
  logic             accept, id_ok;

  always_comb begin
    accept = req_valid & req_ready;
    id_ok  = (req_id <= SEL_W'(NUM_DESIGNS));
  end

  // Outputs are computed from the next state so they can all be registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sel_d    = design_select;
    n_rst_d  = design_n_rst;
    active_d = active_id;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (kill) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      target_d = '0;
      sel_d    = '0;
      n_rst_d  = 1'b0;
      active_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: begin
          if (accept) begin
            if (id_ok) begin
              // Select stays on the old design through quiesce; only its reset drops.
              target_d = req_id;
              state_d  = S_QUIESCE;
              cnt_d    = CNT_W'(QUIESCE_CYCLES - 1);
              n_rst_d  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_QUIESCE: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            sel_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (target_q == '0) begin
            state_d  = S_IDLE;
            active_d = '0;
            done_d   = 1'b1;
          end else begin
            state_d = S_HOLD;
            cnt_d   = CNT_W'(RST_HOLD_CYCLES - 1);
            sel_d   = target_q;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d  = S_RUN;
            n_rst_d  = 1'b1;
            active_d = target_q;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          target_d = '0;
          sel_d    = '0;
          n_rst_d  = 1'b0;
          active_d = '0;
        end
      endcase
    end

    ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
    busy_d  = (state_d == S_QUIESCE) || (state_d == S_GAP) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      target_q      <= '0;
      design_select <= '0;
      design_n_rst  <= 1'b0;
      active_id     <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      design_select <= sel_d;
      design_n_rst  <= n_rst_d;
      active_id     <= active_d;
      req_ready     <= ready_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_design_sel_ctrl.sv
// Self-checking bench for design_sel_ctrl: directed scenarios plus random traffic
// against a cycles-since-accept timeline model.
module tb_design_sel_ctrl;

  localparam int N = 12;
  localparam int W = 4;
  localparam int Q = 16;
  localparam int R = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [W-1:0] req_id;
  logic         req_ready;
  logic         kill;
  logic [W-1:0] design_select;
  logic         design_n_rst;
  logic [W-1:0] active_id;
  logic         busy;
  logic         done;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a switch is a fixed timeline measured from its accept edge.
  logic m_busy   = 1'b0;
  int   m_e      = 0;
  int   m_old    = 0;
  int   m_tgt    = 0;
  int   m_active = 0;
  logic m_done   = 1'b0;
  logic m_err    = 1'b0;

  design_sel_ctrl #(
    .NUM_DESIGNS    (N),
    .SEL_W          (W),
    .QUIESCE_CYCLES (Q),
    .RST_HOLD_CYCLES(R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_id       (req_id),
    .req_ready    (req_ready),
    .kill         (kill),
    .design_select(design_select),
    .design_n_rst (design_n_rst),
    .active_id    (active_id),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_busy   = 1'b0;
      m_e      = 0;
      m_active = 0;
    end else if (kill) begin
      m_busy   = 1'b0;
      m_e      = 0;
      m_active = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        if (int'(req_id) > N) begin
          m_err = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_e    = 1;
          m_old  = m_active;
          m_tgt  = int'(req_id);
        end
      end
    end else begin
      m_e++;
      if (m_tgt == 0 && m_e == Q + 2) begin
        m_busy   = 1'b0;
        m_active = 0;
        m_done   = 1'b1;
      end else if (m_tgt != 0 && m_e == Q + R + 2) begin
        m_busy   = 1'b0;
        m_active = m_tgt;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int exp_sel;
    int exp_nrst;
    if (!m_busy) begin
      exp_sel  = m_active;
      exp_nrst = (m_active != 0) ? 1 : 0;
      check("active_id", int'(active_id), m_active);
    end else begin
      exp_sel  = (m_e <= Q) ? m_old : ((m_e == Q + 1) ? 0 : m_tgt);
      exp_nrst = 0;
    end
    check("design_select", int'(design_select), exp_sel);
    check("design_n_rst", int'(design_n_rst), exp_nrst);
    check("req_ready", int'(req_ready), m_busy ? 0 : 1);
    check("busy", int'(busy), m_busy ? 1 : 0);
    check("done", int'(done), m_done ? 1 : 0);
    check("err", int'(err), m_err ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input int id);
    req_valid = 1'b1;
    req_id    = W'(id);
    step();
    req_valid = 1'b0;
  endtask

  // Counts observed cycles after the accept edge until done; bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    check(tag, lat, exp_lat);
  endtask

  initial begin
    rst       = 1'b1;
    kill      = 1'b0;
    req_valid = 1'b0;
    req_id    = '0;
    steps(2);
    rst = 1'b0;
    steps(2);

    // Idle -> 3: done on cycle 26.
    request(3);
    wait_done("lat_0_to_3", Q + R + 2);
    check("active_after_3", int'(active_id), 3);
    steps(2);

    // 3 -> 7.
    request(7);
    wait_done("lat_3_to_7", Q + R + 2);
    steps(2);

    // 7 -> 5, then out-of-range 13 and 15 are rejected.
    request(5);
    wait_done("lat_7_to_5", Q + R + 2);
    request(13);
    steps(2);
    request(15);
    check("sel_after_err", int'(design_select), 5);
    steps(2);

    // Switch to 9 killed part-way, then an immediate new request.
    request(9);
    steps(18);
    kill = 1'b1;
    step();
    kill = 1'b0;
    request(2);
    wait_done("lat_after_kill", Q + R + 2);

    // Kill together with a request in RUN: request dropped, no err.
    kill      = 1'b1;
    req_valid = 1'b1;
    req_id    = 4'd14;
    step();
    kill      = 1'b0;
    req_valid = 1'b0;
    steps(2);

    // Idle -> 4 -> 0.
    request(4);
    wait_done("lat_0_to_4", Q + R + 2);
    request(0);
    wait_done("lat_4_to_0", Q + 2);
    steps(2);

    // Request 0 from IDLE.
    request(0);
    wait_done("lat_0_to_0", Q + 2);

    // rst in the middle of a switch.
    request(6);
    steps(9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(2);

    // Soft reset of 4 with req_valid held high throughout.
    request(4);
    wait_done("lat_0_to_4b", Q + R + 2);
    req_valid = 1'b1;
    req_id    = 4'd4;
    step();
    wait_done("lat_soft_4", Q + R + 2);
    req_valid = 1'b0;
    steps(Q + R + 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 99) < 30);
      req_id    = W'($urandom_range(0, 15));
      kill      = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst       = 1'b0;
    kill      = 1'b0;
    req_valid = 1'b0;
    steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
